// File: rtl/pulpemu_pkg.sv
// Shared types and helpers for the PULP emulator reset sequencer.
package pulpemu_pkg;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StFilter   = 2'd1,
    StStretch  = 2'd2,
    StRun      = 2'd3
  } state_e;

  localparam logic [7:0] RstCountMax = 8'hFF;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulpemu_sync.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module pulpemu_sync (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pulpemu_reset_seq.sv
// PULP chip reset sequencer: qualifies clock lock, stretches reset, latches boot mode,
// and re-enters the stretch on a software reset request.
module pulpemu_reset_seq
  import pulpemu_pkg::*;
#(
  parameter int unsigned LOCK_FILTER    = 16,
  parameter int unsigned STRETCH_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clk_locked_i,
  input  logic       sw_rst_req_i,
  input  logic       bootsel_i,
  output logic       pulp_rstn_o,
  output logic       bootsel_o,
  output logic [1:0] state_o,
  output logic [7:0] rst_count_o
);

  localparam int unsigned CntW = $clog2(max_u(LOCK_FILTER, STRETCH_CYCLES)) + 1;

  logic            lock_s;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sw_prev_q, sw_rise;
  logic            pulp_rstn_q;
  logic            bootsel_q, bootsel_d;
  logic [7:0]      rst_count_q, rst_count_d;

  pulpemu_sync u_lock_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (clk_locked_i),
    .q_o    (lock_s)
  );

  assign sw_rise = sw_rst_req_i & ~sw_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bootsel_d = bootsel_q;
    case (state_q)
      StWaitLock: begin
        if (lock_s) begin
          state_d = StFilter;
          cnt_d   = '0;
        end
      end
      StFilter: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(LOCK_FILTER - 1)) begin
          state_d = StStretch;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStretch: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(STRETCH_CYCLES - 1)) begin
          state_d   = StRun;
          cnt_d     = '0;
          bootsel_d = bootsel_i;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        // Lock loss wins over a simultaneous software request.
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (sw_rise) begin
          state_d = StStretch;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rst_count_d = rst_count_q;
    if (state_q == StRun && state_d != StRun && rst_count_q != RstCountMax) begin
      rst_count_d = rst_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StWaitLock;
      cnt_q       <= '0;
      sw_prev_q   <= 1'b0;
      pulp_rstn_q <= 1'b0;
      bootsel_q   <= 1'b0;
      rst_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sw_prev_q   <= sw_rst_req_i;
      // Registered from next state so the pad reset is glitch-free and tracks state RUN.
      pulp_rstn_q <= (state_d == StRun);
      bootsel_q   <= bootsel_d;
      rst_count_q <= rst_count_d;
    end
  end

  assign pulp_rstn_o = pulp_rstn_q;
  assign bootsel_o   = bootsel_q;
  assign state_o     = state_q;
  assign rst_count_o = rst_count_q;

endmodule
